ref_sc_fifo_wr_arbiter: RTL and testbench
=========================================

Name: ref_sc_fifo_wr_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_REQ requester streams into the write port of one single-clock shallow FIFO.
- Each beat written is tagged with its source ID and an end-of-packet (EOP) flag.
- Optional atomic mode: a packet is granted only when the FIFO has room for a whole maximum-size packet, so partial packets never stall inside the FIFO.
- Sits between DMA engine request sources and the FIFO write side; consumes the FIFO's registered wr_level/wr_full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, source-ID tag width; 2^ID_WIDTH >= NUM_REQ.
- DATA_WIDTH, 64, payload width per requester.
- FIFO_ADDR_WIDTH, 4, address width of the downstream FIFO; depth = 2^FIFO_ADDR_WIDTH.
- PKT_ATOMIC, 0, 1 = grant only when free space >= MAX_PKT_WORDS.
- MAX_PKT_WORDS, 8, maximum packet length in beats; must be <= FIFO depth.

Ports:
- clk  in  1  clock, positive edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort/flush request.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_eop  in  NUM_REQ  per-requester last beat of packet.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester beat accepted.
- fifo_flush  out  1  flush to the FIFO; equals flush (combinational).
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  ID_WIDTH+1+DATA_WIDTH  {src_id, eop, data}.
- fifo_wr_level  in  FIFO_ADDR_WIDTH+1  FIFO registered write level.
- fifo_wr_full  in  1  FIFO registered full flag.
- grant  out  NUM_REQ  one-hot current owner; all zeros when idle.
- busy  out  1  a packet transfer is in progress.

Behaviour:
Reset (rst_n low, asynchronous):
- state=IDLE, grant=0, busy=0, req_ready=0, fifo_wr_en=0.
- Round-robin pointer last_id=NUM_REQ-1, so requester 0 has first priority.

States:
- IDLE: evaluated each cycle.
  - Candidates are requesters with req_valid=1.
  - Winner is the first candidate searching upward from last_id+1, wrapping at NUM_REQ-1 -> 0.
  - Space check: with PKT_ATOMIC=1, arbitration is allowed only if (2^FIFO_ADDR_WIDTH - fifo_wr_level) >= MAX_PKT_WORDS, computed at FIFO_ADDR_WIDTH+2 bits, unsigned. With PKT_ATOMIC=0 there is no space check.
  - If a winner exists and the space check passes: register grant=onehot(winner), cur_id=winner, go to XFER.
  - No beats are accepted in IDLE, so there is exactly one bubble cycle between packets.
- XFER: busy=1.
  - req_ready[cur_id] = !fifo_wr_full; all other req_ready bits are 0.
  - Accept = req_valid[cur_id] & req_ready[cur_id].
  - fifo_wr_en = accept (combinational).
  - fifo_wr_data = {cur_id, req_eop[cur_id], req_data[cur_id]}.
  - On accept with eop=1: last_id <= cur_id, grant <= 0, state <= IDLE.
  - A valid gap (req_valid low mid-packet) holds the grant indefinitely; there is no timeout.

Flow control and latency:
- fifo_wr_full is trusted as registered by the FIFO: a write accepted at edge N reflects in fifo_wr_full after edge N.
- The arbiter never asserts fifo_wr_en while fifo_wr_full=1.
- Latency: the first beat of a granted packet can be written in the cycle after the grant edge. Beat throughput is 1 per clock in XFER.

Flush:
- While flush=1: req_ready=0, fifo_wr_en=0.
- At the edge: state <= IDLE, grant <= 0, last_id <= NUM_REQ-1.
- A partially transferred packet is discarded; the requester is responsible for restarting it.
- Flush has priority over EOP completion in the same cycle.

Simultaneous events:
- A requester asserting valid during another's XFER waits; it is evaluated on the next IDLE cycle.
- Single-beat packets (eop on the first beat) take 2 cycles per packet: IDLE plus XFER.

Width/constraints:
- src_id is zero-extended to ID_WIDTH.
- req_data/req_eop of non-granted requesters are ignored.
- Simulation-only check: error if fifo_wr_en & fifo_wr_full, or if grant is not one-hot while busy.

Test Plan:
1. Reset, then req 0 sends a 3-beat packet with FIFO empty -> grant=0001 one cycle after valid; 3 consecutive fifo_wr_en beats with src_id=0 and eop only on beat 3; busy drops after beat 3; FIFO level 3.
2. All 4 requesters continuously valid with 2-beat packets -> grant order 0,1,2,3,0; each packet is 2 writes followed by a 1-cycle bubble; 15 cycles for the first 5 packets.
3. FIFO depth 16, PKT_ATOMIC=0, single requester streaming a 20-beat packet, no reads -> writes stop after 16 beats; req_ready=0 while full; each read-ack of 1 beat admits exactly 1 further beat; no write while full.
4. PKT_ATOMIC=1, MAX_PKT_WORDS=8, fifo_wr_level=9 -> no grant despite req_valid; after the level drops to 8, grant in the next IDLE cycle.
5. Flush asserted during beat 2 of a 4-beat packet from req 2 -> fifo_flush=1 that cycle, no write, state IDLE; next arbitration with reqs 1 and 2 valid grants req 0 if valid, else 1.
6. Async rst_n low mid-XFER -> grant=0, req_ready=0, fifo_wr_en=0 immediately without a clock edge; after release, requester 0 wins the first contention.

Source files
------------

// File: rtl/ref_sc_fifo_wr_arbiter.sv
// +----------------------------------------------------------------------------+
// | ref_sc_fifo_wr_arbiter                                                     |
// | Packet-granular round-robin merge of NUM_REQ streams into one FIFO write.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ref_sc_fifo_wr_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_WIDTH        = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PKT_ATOMIC      = 0,
  parameter int MAX_PKT_WORDS   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_eop,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               fifo_flush,
  output logic                               fifo_wr_en,
  output logic [ID_WIDTH+DATA_WIDTH:0]       fifo_wr_data,
  input  logic [FIFO_ADDR_WIDTH:0]           fifo_wr_level,
  input  logic                               fifo_wr_full,
  output logic [NUM_REQ-1:0]                 grant,
  output logic                               busy
);

  localparam logic [FIFO_ADDR_WIDTH+1:0] c_depth    = (FIFO_ADDR_WIDTH+2)'(2**FIFO_ADDR_WIDTH);
  localparam logic [FIFO_ADDR_WIDTH+1:0] c_max_pkt  = (FIFO_ADDR_WIDTH+2)'(MAX_PKT_WORDS);
  localparam logic [ID_WIDTH-1:0]        c_last_rst = ID_WIDTH'(NUM_REQ-1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ID_WIDTH-1:0]     r_cur_id;
  logic [ID_WIDTH-1:0]     r_last_id;
  logic [NUM_REQ-1:0]      r_grant;
  logic                    r_busy;

  logic [FIFO_ADDR_WIDTH+1:0] w_free;
  logic                       w_space_ok;
  logic                       w_hi_found;
  logic                       w_lo_found;
  logic [ID_WIDTH-1:0]        w_hi_id;
  logic [ID_WIDTH-1:0]        w_lo_id;
  logic                       w_win_found;
  logic [ID_WIDTH-1:0]        w_win_id;
  logic [NUM_REQ-1:0]         w_win_onehot;
  logic                       w_xfer;
  logic                       w_accept;
  logic                       w_cur_eop;
  logic [DATA_WIDTH-1:0]      w_cur_data;

  assign w_free     = c_depth - {1'b0, fifo_wr_level};
  assign w_space_ok = (PKT_ATOMIC == 0) || (w_free >= c_max_pkt);

  // Round robin: the lowest valid index above last_id wins, else the lowest at or below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_id    = '0;
    w_lo_id    = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (ID_WIDTH'(i) > r_last_id) begin
          w_hi_found = 1'b1;
          w_hi_id    = ID_WIDTH'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_id    = ID_WIDTH'(i);
        end
      end
    end
  end

  assign w_win_found = w_hi_found | w_lo_found;
  assign w_win_id    = w_hi_found ? w_hi_id : w_lo_id;

  always_comb begin
    w_win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_onehot[i] = (ID_WIDTH'(i) == w_win_id);
    end
  end

  always_comb begin
    w_cur_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_cur_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_cur_eop  = |(req_eop & r_grant);
  assign w_xfer     = (r_state == ST_XFER) && !flush;
  assign req_ready  = (w_xfer && !fifo_wr_full) ? r_grant : '0;
  assign w_accept   = |(req_valid & req_ready);

  assign fifo_flush   = flush;
  assign fifo_wr_en   = w_accept;
  assign fifo_wr_data = {r_cur_id, w_cur_eop, w_cur_data};
  assign grant        = r_grant;
  assign busy         = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cur_id  <= '0;
      r_last_id <= c_last_rst;
      r_grant   <= '0;
      r_busy    <= 1'b0;
    end else if (flush) begin
      // Flush outranks any EOP completing this cycle; the packet is dropped.
      r_state   <= ST_IDLE;
      r_last_id <= c_last_rst;
      r_grant   <= '0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_win_found && w_space_ok) begin
            r_state  <= ST_XFER;
            r_cur_id <= w_win_id;
            r_grant  <= w_win_onehot;
            r_busy   <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_accept && w_cur_eop) begin
            r_state   <= ST_IDLE;
            r_last_id <= r_cur_id;
            r_grant   <= '0;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr_en && fifo_wr_full));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    r_busy |-> $onehot(r_grant));
`endif

endmodule

`default_nettype wire

// File: tb/tb_ref_sc_fifo_wr_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_ref_sc_fifo_wr_arbiter                                                  |
// | Randomized bench against a packet-level reference model and FIFO model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ref_sc_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MAXP  = 8;
  localparam int WW    = IDW + 1 + DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_eop = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_flush;
  logic            fifo_wr_en;
  logic [WW-1:0]   fifo_wr_data;
  logic [AW:0]     fifo_wr_level = '0;
  logic            fifo_wr_full = 1'b0;
  logic [N-1:0]    grant;
  logic            busy;

  always #5 clk = ~clk;

  ref_sc_fifo_wr_arbiter #(
    .NUM_REQ(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW),
    .PKT_ATOMIC(1), .MAX_PKT_WORDS(MAXP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_eop(req_eop), .req_data(req_data),
    .req_ready(req_ready), .fifo_flush(fifo_flush), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_level(fifo_wr_level),
    .fifo_wr_full(fifo_wr_full), .grant(grant), .busy(busy)
  );

  int n_checks = 0;
  int n_err = 0;

  // Reference model: owning requester (-1 when idle) and last packet winner.
  int m_owner = -1;
  int m_last  = N-1;
  int lvl     = 0;

  int beat[N], len[N], pkt[N];
  logic [31:0] salt[N];
  logic [N-1:0] act = '0;
  int vprob = 100, rd_prob = 0, flush_prob = 0, fix_len = 1;

  int cyc = 0, obs_wr = 0, obs_wr_full = 0;
  int eop_src[$];
  int eop_cyc[$];

  task automatic check_eq(input string tag, input logic [127:0] act_v, input logic [127:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act_v, exp_v, cyc);
    end
  endtask

  task automatic restart(input int i);
    beat[i] = 0;
    len[i]  = (fix_len > 0) ? fix_len : int'($urandom_range(1, MAXP));
    pkt[i]++;
    salt[i] = $urandom;
  endtask

  task automatic restart_all();
    for (int i = 0; i < N; i++) restart(i);
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = act[i] && (int'($urandom_range(99)) < vprob);
      req_eop[i]   = (beat[i] == len[i] - 1);
      req_data[i*DW +: DW] = {salt[i], 8'(i), 8'(pkt[i]), 16'(beat[i])};
    end
    fifo_wr_level = (AW+1)'(lvl);
    fifo_wr_full  = (lvl == DEPTH);
    flush = (int'($urandom_range(999)) < flush_prob);
  endtask

  // One clock: compare at mid-cycle, then advance the model across the edge.
  task automatic tick();
    logic [N-1:0]  e_grant, e_ready;
    logic          e_wr, e_eop, rd, found;
    logic [WW-1:0] e_data;
    int c;
    #2;
    e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_ready = (m_owner >= 0 && !flush && lvl < DEPTH) ? e_grant : '0;
    e_wr    = |(e_ready & req_valid);
    e_eop   = (m_owner >= 0) ? req_eop[m_owner] : 1'b0;
    e_data  = '0;
    if (m_owner >= 0) e_data = {IDW'(m_owner), req_eop[m_owner], req_data[m_owner*DW +: DW]};
    check_eq("grant", grant, e_grant);
    check_eq("busy", busy, m_owner >= 0);
    check_eq("req_ready", req_ready, e_ready);
    check_eq("fifo_wr_en", fifo_wr_en, e_wr);
    check_eq("fifo_flush", fifo_flush, flush);
    if (e_wr) check_eq("wr_data", fifo_wr_data, e_data);
    if (fifo_wr_en) begin
      obs_wr++;
      if (fifo_wr_full) obs_wr_full++;
      if (fifo_wr_data[DW]) begin
        eop_src.push_back(int'(fifo_wr_data[WW-1 -: IDW]));
        eop_cyc.push_back(cyc);
      end
    end
    rd = (lvl > 0) && (int'($urandom_range(99)) < rd_prob);
    @(posedge clk);
    #1;
    cyc++;
    if (flush) begin
      m_owner = -1;
      m_last  = N-1;
      restart_all();
      lvl = 0;
    end else begin
      if (m_owner < 0) begin
        if (DEPTH - lvl >= MAXP) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (!found && req_valid[c]) begin
              found   = 1'b1;
              m_owner = c;
            end
          end
        end
      end else if (e_wr) begin
        if (e_eop) begin
          m_last = m_owner;
          restart(m_owner);
          m_owner = -1;
        end else begin
          beat[m_owner]++;
        end
      end
      lvl = lvl + int'(e_wr) - int'(rd);
    end
    apply_inputs();
  endtask

  task automatic drain();
    act = '0;
    rd_prob = 100;
    apply_inputs();
    for (int t = 0; t < 40 && (lvl > 0 || m_owner >= 0); t++) tick();
    check_eq("drain_idle", busy, 1'b0);
  endtask

  initial begin
    int c0, w0;
    for (int i = 0; i < N; i++) begin
      pkt[i] = 0;
      restart(i);
    end
    // Reset with requests pending
    act = '1;
    apply_inputs();
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_grant", grant, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", req_ready, '0);
    check_eq("rst_wr_en", fifo_wr_en, 1'b0);
    rst_n = 1'b1;

    // Single 3-beat packet from requester 0
    act = 4'b0001; fix_len = 3; restart_all(); apply_inputs();
    obs_wr = 0; eop_src.delete();
    for (int t = 0; t < 20 && eop_src.size() < 1; t++) tick();
    check_eq("p1_done", eop_src.size(), 1);
    check_eq("p1_beats", obs_wr, 3);
    if (eop_src.size() > 0) check_eq("p1_src", eop_src[0], 0);
    act = '0; apply_inputs();
    drain();

    // Flush idle arbiter so the pointer restarts, then 2-beat round robin
    flush = 1'b1;
    tick();
    act = '1; fix_len = 2; rd_prob = 100; restart_all(); apply_inputs();
    c0 = cyc; eop_src.delete(); eop_cyc.delete();
    for (int t = 0; t < 40 && eop_src.size() < 5; t++) tick();
    check_eq("rr_done", eop_src.size(), 5);
    if (eop_src.size() >= 5) begin
      for (int p = 0; p < 5; p++) check_eq("rr_order", eop_src[p], p % N);
      check_eq("rr_cycles", eop_cyc[4] - c0, 14);
    end
    act = '0; apply_inputs();
    drain();

    // 20-beat packet against a 16-deep FIFO without reads
    act = 4'b0001; fix_len = 20; rd_prob = 0; restart_all(); apply_inputs();
    obs_wr = 0; obs_wr_full = 0; eop_src.delete();
    repeat (25) tick();
    check_eq("full_stop", obs_wr, 16);
    for (int r = 0; r < 2; r++) begin
      w0 = obs_wr;
      rd_prob = 100; tick();
      rd_prob = 0; repeat (3) tick();
      check_eq("read_admits_one", obs_wr - w0, 1);
    end
    rd_prob = 100;
    for (int t = 0; t < 20 && eop_src.size() < 1; t++) tick();
    check_eq("long_done", eop_src.size(), 1);
    check_eq("wr_while_full", obs_wr_full, 0);
    act = '0; apply_inputs();
    drain();

    // Atomic space check: level 9 blocks, level 8 grants
    lvl = 9; act = 4'b0001; fix_len = 2; rd_prob = 0; restart_all(); apply_inputs();
    repeat (5) tick();
    check_eq("atomic_block", busy, 1'b0);
    lvl = 8; apply_inputs();
    tick();
    check_eq("atomic_grant", grant, 4'b0001);
    eop_src.delete();
    for (int t = 0; t < 10 && eop_src.size() < 1; t++) tick();
    check_eq("atomic_done", eop_src.size(), 1);
    act = '0; apply_inputs();
    drain();

    // Flush during beat 2 of requester 2's 4-beat packet
    act = 4'b0100; fix_len = 4; rd_prob = 0; restart_all(); apply_inputs();
    for (int t = 0; t < 10 && !(m_owner == 2 && beat[2] == 1); t++) tick();
    check_eq("flush_setup", busy, 1'b1);
    flush = 1'b1;
    tick();
    check_eq("flush_grant", grant, '0);
    check_eq("flush_busy", busy, 1'b0);
    act = 4'b0110; apply_inputs();
    eop_src.delete();
    for (int t = 0; t < 30 && eop_src.size() < 1; t++) tick();
    check_eq("flush_next_done", eop_src.size(), 1);
    if (eop_src.size() > 0) check_eq("flush_next_src", eop_src[0], 1);
    act = '0; apply_inputs();
    drain();

    // Randomized traffic with reads and occasional flushes
    act = '1; fix_len = 0; vprob = 70; rd_prob = 45; flush_prob = 4;
    restart_all(); apply_inputs();
    repeat (3000) tick();
    flush_prob = 0; vprob = 100; act = '0; fix_len = 8;
    flush = 1'b1;
    tick();
    drain();

    // Asynchronous reset in the middle of a packet
    act = 4'b0010; rd_prob = 0; restart_all(); apply_inputs();
    for (int t = 0; t < 10 && !(m_owner == 1 && beat[1] >= 2); t++) tick();
    check_eq("arst_setup", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_grant", grant, '0);
    check_eq("arst_ready", req_ready, '0);
    check_eq("arst_wr_en", fifo_wr_en, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    m_owner = -1; m_last = N-1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    act = '1; restart_all(); apply_inputs();
    eop_src.delete();
    for (int t = 0; t < 20 && eop_src.size() < 1; t++) tick();
    check_eq("arst_next_done", eop_src.size(), 1);
    if (eop_src.size() > 0) check_eq("arst_next_src", eop_src[0], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
